mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 184 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding data-memory access, big-endian lanes, bus wait timeout.
// Optional LSU_MISALIGN_EXC_EN: raise a misalignment error instead of force-aligning the address.
module mem_lsu #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [31:0]       op_wdata,
    input  logic [4:0]        op_rdest,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_sel,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rdest,
    output logic [31:0]       wb_data,
    output logic              stall,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t              r_state, w_next;
    logic [15:0]         r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_sel;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic [2:0]          r_ldcode;
    logic [1:0]          r_off;
    logic [4:0]          r_rdest_q;
    logic [4:0]          r_wb_rdest;
    logic [31:0]         r_wb_data;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic                w_illegal, w_is_load, w_byte, w_half, w_reject, w_accept, w_timeout;
    logic [1:0]          w_off;
    logic [3:0]          w_sel;
    logic [31:0]         w_wdata;
    logic [7:0]          w_lbyte;
    logic [15:0]         w_lhalf;
    logic [31:0]         w_ldata;

    always_comb begin
        w_illegal = op_code[3];
        w_is_load = (op_code <= 4'd4);
        w_byte    = (op_code == 4'd0) || (op_code == 4'd1) || (op_code == 4'd5);
        w_half    = (op_code == 4'd2) || (op_code == 4'd3) || (op_code == 4'd6);
        // Lane offset drops the low address bits a wider access cannot use.
        if (w_byte)      w_off = op_addr[1:0];
        else if (w_half) w_off = {op_addr[1], 1'b0};
        else             w_off = 2'b00;
        w_sel = 4'b1111;
        if (w_byte) begin
            case (w_off)
                2'd0:    w_sel = 4'b1000;
                2'd1:    w_sel = 4'b0100;
                2'd2:    w_sel = 4'b0010;
                default: w_sel = 4'b0001;
            endcase
        end else if (w_half) begin
            w_sel = w_off[1] ? 4'b0011 : 4'b1100;
        end
        if (w_byte)      w_wdata = {4{op_wdata[7:0]}};
        else if (w_half) w_wdata = {2{op_wdata[15:0]}};
        else             w_wdata = op_wdata;
`ifdef LSU_MISALIGN_EXC_EN
        w_reject = w_illegal || (w_half && op_addr[0]) || (!w_byte && !w_half && (op_addr[1:0] != 2'b00));
`else
        w_reject = w_illegal;
`endif
        w_accept  = (r_state == S_IDLE) && op_valid && !w_reject;
        w_timeout = (({1'b0, r_cnt} + 17'd1) == 17'(TIMEOUT_CYC));
    end

    always_comb begin
        case (r_off)
            2'd0:    w_lbyte = bus_rdata[31:24];
            2'd1:    w_lbyte = bus_rdata[23:16];
            2'd2:    w_lbyte = bus_rdata[15:8];
            default: w_lbyte = bus_rdata[7:0];
        endcase
        w_lhalf = r_off[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        case (r_ldcode)
            3'd0:    w_ldata = {{24{w_lbyte[7]}}, w_lbyte};
            3'd1:    w_ldata = {24'd0, w_lbyte};
            3'd2:    w_ldata = {{16{w_lhalf[15]}}, w_lhalf};
            3'd3:    w_ldata = {16'd0, w_lhalf};
            default: w_ldata = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Ack wins over timeout when both land in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (bus_ack)        w_next = r_we ? S_IDLE : S_RESP;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_sel      <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_ldcode   <= '0;
            r_off      <= '0;
            r_rdest_q  <= '0;
            r_wb_rdest <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
            r_err_code <= '0;
        end else begin
            r_err <= 1'b0;
            if (r_state == S_IDLE && op_valid) begin
                if (w_illegal) begin
                    r_err      <= 1'b1;
                    r_err_code <= 2'd3;
                end else if (w_reject) begin
                    r_err      <= 1'b1;
                    r_err_code <= 2'd2;
                end else begin
                    r_addr    <= {op_addr[ADDR_W-1:2], 2'b00};
                    r_sel     <= w_sel;
                    r_wdata   <= w_wdata;
                    r_we      <= !w_is_load;
                    r_ldcode  <= op_code[2:0];
                    r_off     <= w_off;
                    r_rdest_q <= op_rdest;
                    r_cnt     <= '0;
                end
            end else if (r_state == S_REQ) begin
                if (bus_ack) begin
                    if (!r_we) begin
                        r_wb_data  <= w_ldata;
                        r_wb_rdest <= r_rdest_q;
                    end
                end else if (w_timeout) begin
                    r_err      <= 1'b1;
                    r_err_code <= 2'd1;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign op_ready  = (r_state == S_IDLE);
    assign stall     = !op_ready;
    assign bus_req   = (r_state == S_REQ);
    assign bus_we    = (r_state == S_REQ) && r_we;
    assign bus_addr  = r_addr;
    assign bus_sel   = r_sel;
    assign bus_wdata = r_wdata;
    assign wb_valid  = (r_state == S_RESP);
    assign wb_rdest  = r_wb_rdest;
    assign wb_data   = r_wb_data;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected bus accesses and writebacks are queued at issue time.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rdest;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rdest;
    logic [31:0] wb_data;
    logic        stall;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rdest(op_rdest),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_rdest(wb_rdest), .wb_data(wb_data),
        .stall(stall), .err(err), .err_code(err_code)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } op_t;

    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for op_ready, then presents one op for a single cycle.
    task automatic issue(input logic [3:0] code, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int n = 0;
        while (!op_ready && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (op_ready !== 1'b1) begin
            $display("FAIL issue_ready: op_ready=%b required 1 after %0d cycles", op_ready, n);
            n_fail++;
        end
        op_valid = 1'b1; op_code = code; op_addr = addr; op_wdata = wdata; op_rdest = rd;
        tick();
        op_valid = 1'b0;
    endtask

    // Runs a list of legal ops through issue, bus wait, ack and writeback.
    task automatic run_ops(input op_t ops[$], input string tag);
        bus_exp_t be;
        wb_exp_t  we;
        foreach (ops[k]) begin
            bus_q.push_back('{ops[k].exp_addr, ops[k].exp_sel, (ops[k].code >= 4'd5), ops[k].exp_wdata});
            if (ops[k].code <= 4'd4) wb_q.push_back('{ops[k].rd, ops[k].exp_data});
            issue(ops[k].code, ops[k].addr, ops[k].wdata, ops[k].rd);
            be = bus_q.pop_front();
            n_checks++;
            if (bus_req !== 1'b1 || bus_addr !== be.addr || bus_sel !== be.sel || bus_we !== be.we) begin
                $display("FAIL %s_bus[%0d]: req=%b addr=%h sel=%b we=%b required 1 %h %b %b",
                         tag, k, bus_req, bus_addr, bus_sel, bus_we, be.addr, be.sel, be.we);
                n_fail++;
            end
            if (be.we) begin
                n_checks++;
                if (bus_wdata !== be.wdata) begin
                    $display("FAIL %s_wdata[%0d]: got %h required %h", tag, k, bus_wdata, be.wdata);
                    n_fail++;
                end
            end
            for (int d = 0; d < ops[k].delay; d++) begin
                tick();
                n_checks++;
                if (bus_req !== 1'b1 || bus_addr !== be.addr || bus_sel !== be.sel) begin
                    $display("FAIL %s_hold[%0d]: req=%b addr=%h sel=%b required 1 %h %b",
                             tag, k, bus_req, bus_addr, bus_sel, be.addr, be.sel);
                    n_fail++;
                end
            end
            bus_ack = 1'b1; bus_rdata = ops[k].rdata;
            tick();
            bus_ack = 1'b0; bus_rdata = 32'h0BAD_0BAD;
            if (ops[k].code <= 4'd4) begin
                we = wb_q.pop_front();
                n_checks++;
                if (wb_valid !== 1'b1 || wb_rdest !== we.rd || wb_data !== we.data) begin
                    $display("FAIL %s_wb[%0d]: valid=%b rd=%0d data=%h required 1 %0d %h",
                             tag, k, wb_valid, wb_rdest, wb_data, we.rd, we.data);
                    n_fail++;
                end
                tick();
                n_checks++;
                if (wb_valid !== 1'b0 || op_ready !== 1'b1 || wb_data !== we.data || err !== 1'b0) begin
                    $display("FAIL %s_after_wb[%0d]: valid=%b ready=%b data=%h err=%b required 0 1 %h 0",
                             tag, k, wb_valid, op_ready, wb_data, err, we.data);
                    n_fail++;
                end
            end else begin
                n_checks++;
                if (wb_valid !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 || op_ready !== 1'b1 || err !== 1'b0) begin
                    $display("FAIL %s_store_done[%0d]: wb=%b req=%b we=%b ready=%b err=%b required 0 0 0 1 0",
                             tag, k, wb_valid, bus_req, bus_we, op_ready, err);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus_req, bus_we, wb_valid, err} !== 4'b0 || bus_addr !== 32'h0 || bus_sel !== 4'h0 ||
            bus_wdata !== 32'h0 || wb_data !== 32'h0 || wb_rdest !== 5'h0 || err_code !== 2'h0) begin
            $display("FAIL reset_outputs: req=%b we=%b wb=%b err=%b addr=%h sel=%b wd=%h data=%h rd=%0d code=%0d required all 0",
                     bus_req, bus_we, wb_valid, err, bus_addr, bus_sel, bus_wdata, wb_data, wb_rdest, err_code);
            n_fail++;
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (op_ready !== 1'b1 || stall !== 1'b0) begin
            $display("FAIL reset_ready: ready=%b stall=%b required 1 0", op_ready, stall);
            n_fail++;
        end
    endtask

    task automatic test_loads;
        op_t ops[$];
        ops.push_back('{4'd0, 32'h1001, 32'h0, 5'd5, 3, 32'h12F45678, 32'h1000, 4'b0100, 32'h0, 32'hFFFFFFF4});
        ops.push_back('{4'd1, 32'h1003, 32'h0, 5'd6, 0, 32'h12F45680, 32'h1000, 4'b0001, 32'h0, 32'h00000080});
        ops.push_back('{4'd2, 32'h1002, 32'h0, 5'd7, 1, 32'h12348001, 32'h1000, 4'b0011, 32'h0, 32'hFFFF8001});
        ops.push_back('{4'd3, 32'h1000, 32'h0, 5'd8, 2, 32'h80011234, 32'h1000, 4'b1100, 32'h0, 32'h00008001});
        ops.push_back('{4'd4, 32'h1004, 32'h0, 5'd9, 0, 32'hDEADBEEF, 32'h1004, 4'b1111, 32'h0, 32'hDEADBEEF});
        ops.push_back('{4'd0, 32'h1000, 32'h0, 5'd10, 0, 32'h7F000000, 32'h1000, 4'b1000, 32'h0, 32'h0000007F});
        ops.push_back('{4'd1, 32'h1002, 32'h0, 5'd11, 0, 32'h0000FF00, 32'h1000, 4'b0010, 32'h0, 32'h000000FF});
        run_ops(ops, "load");
    endtask

    task automatic test_stores;
        op_t ops[$];
        ops.push_back('{4'd6, 32'h2002, 32'h0000BEEF, 5'd0, 1, 32'h0, 32'h2000, 4'b0011, 32'hBEEFBEEF, 32'h0});
        ops.push_back('{4'd5, 32'h5003, 32'h12345678, 5'd0, 0, 32'h0, 32'h5000, 4'b0001, 32'h78787878, 32'h0});
        ops.push_back('{4'd5, 32'h5000, 32'h000000A5, 5'd0, 2, 32'h0, 32'h5000, 4'b1000, 32'hA5A5A5A5, 32'h0});
        ops.push_back('{4'd7, 32'h6000, 32'hCAFEF00D, 5'd0, 0, 32'h0, 32'h6000, 4'b1111, 32'hCAFEF00D, 32'h0});
        run_ops(ops, "store");
    endtask

    task automatic test_timeout;
        issue(4'd4, 32'h3000, 32'h0, 5'd12);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (bus_req !== 1'b1 || err !== 1'b0) begin
                $display("FAIL timeout_wait[%0d]: req=%b err=%b required 1 0", c, bus_req, err);
                n_fail++;
            end
            tick();
        end
        n_checks++;
        if (bus_req !== 1'b0 || err !== 1'b1 || err_code !== 2'd1 || op_ready !== 1'b1 || wb_valid !== 1'b0) begin
            $display("FAIL timeout_err: req=%b err=%b code=%0d ready=%b wb=%b required 0 1 1 1 0",
                     bus_req, err, err_code, op_ready, wb_valid);
            n_fail++;
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || wb_valid !== 1'b0) begin
            $display("FAIL timeout_pulse: err=%b wb=%b required 0 0", err, wb_valid);
            n_fail++;
        end
    endtask

    task automatic test_illegal;
        issue(4'd9, 32'h9000, 32'h0, 5'd1);
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || bus_req !== 1'b0 || op_ready !== 1'b1) begin
            $display("FAIL illegal_err: err=%b code=%0d req=%b ready=%b required 1 3 0 1",
                     err, err_code, bus_req, op_ready);
            n_fail++;
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || bus_req !== 1'b0) begin
            $display("FAIL illegal_after: err=%b req=%b required 0 0", err, bus_req);
            n_fail++;
        end
    endtask

    task automatic test_misalign;
`ifdef LSU_MISALIGN_EXC_EN
        issue(4'd3, 32'h4001, 32'h0, 5'd2);
        n_checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || bus_req !== 1'b0) begin
            $display("FAIL misalign_err: err=%b code=%0d req=%b required 1 2 0", err, err_code, bus_req);
            n_fail++;
        end
        tick();
        n_checks++;
        if (err !== 1'b0 || bus_req !== 1'b0 || op_ready !== 1'b1) begin
            $display("FAIL misalign_after: err=%b req=%b ready=%b required 0 0 1", err, bus_req, op_ready);
            n_fail++;
        end
`else
        op_t ops[$];
        ops.push_back('{4'd3, 32'h4001, 32'h0, 5'd2, 0, 32'hABCD1234, 32'h4000, 4'b1100, 32'h0, 32'h0000ABCD});
        ops.push_back('{4'd4, 32'h4003, 32'h0, 5'd3, 1, 32'h11223344, 32'h4000, 4'b1111, 32'h0, 32'h11223344});
        ops.push_back('{4'd6, 32'h4007, 32'h00001357, 5'd0, 0, 32'h0, 32'h4004, 4'b0011, 32'h13571357, 32'h0});
        run_ops(ops, "misalign");
`endif
    endtask

    task automatic test_reset_in_req;
        issue(4'd4, 32'h7000, 32'h0, 5'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus_req !== 1'b0 || wb_valid !== 1'b0 || err !== 1'b0 || op_ready !== 1'b1) begin
            $display("FAIL rst_req: req=%b wb=%b err=%b ready=%b required 0 0 0 1",
                     bus_req, wb_valid, err, op_ready);
            n_fail++;
        end
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus_ack = 1'b0;
            n_checks++;
            if (wb_valid !== 1'b0 || err !== 1'b0 || bus_req !== 1'b0) begin
                $display("FAIL rst_quiet[%0d]: wb=%b err=%b req=%b required 0 0 0", c, wb_valid, err, bus_req);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back;
        op_t ops[$];
        ops.push_back('{4'd4, 32'h8000, 32'h0,        5'd3,  0, 32'h01020304, 32'h8000, 4'b1111, 32'h0,        32'h01020304});
        ops.push_back('{4'd7, 32'h8004, 32'hA5A55A5A, 5'd0,  0, 32'h0,        32'h8004, 4'b1111, 32'hA5A55A5A, 32'h0});
        ops.push_back('{4'd4, 32'h8004, 32'h0,        5'd31, 0, 32'hA5A55A5A, 32'h8004, 4'b1111, 32'h0,        32'hA5A55A5A});
        ops.push_back('{4'd2, 32'h8000, 32'h0,        5'd1,  0, 32'h7FFF0000, 32'h8000, 4'b1100, 32'h0,        32'h00007FFF});
        run_ops(ops, "b2b");
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_code = '0; op_addr = '0; op_wdata = '0; op_rdest = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        test_reset();
        test_loads();
        test_stores();
        test_timeout();
        test_illegal();
        test_misalign();
        test_reset_in_req();
        test_back_to_back();
        n_checks++;
        if (bus_q.size() != 0 || wb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: bus_q=%0d wb_q=%0d required 0 0", bus_q.size(), wb_q.size());
            n_fail++;
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
